cnn_cell_engine: RTL and testbench

Sequential, parametrised successor to the single-shot cellular-network cell evaluator. It computes one cell state update from a streamed neighbourhood: x = I + Σ A_k·Y_k + Σ B_k·U_k over TAPS taps. The output nonlinearity is a scaled saturation of x. The engine sits between the neighbourhood fetch logic and the cell-state write-back, with valid/ready handshakes on both sides.

---
 rtl/cnn_cell_pkg.sv | 29 ++
 rtl/cnn_cell_sat.sv | 41 ++++
 rtl/cnn_cell_engine.sv | 131 +++++++++++++
 tb/tb_cnn_cell_engine.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_cell_pkg.sv
// rtl/cnn_cell_pkg.sv - shared types, default sizes and ACC_W sizing helper for cnn_cell_engine
package cnn_cell_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_SAT   = 2'd2,
    ST_OUT   = 2'd3
  } cnn_state_e;

  localparam int CNN_DW    = 8;
  localparam int CNN_YW    = 9;
  localparam int CNN_TAPS  = 9;
  localparam int CNN_ACC_W = 24;

  // Smallest signed width holding I + TAPS*(2^DW-1)*(2^(YW-1)+2^DW-1).
  function automatic int cnn_min_acc_w(input int taps, input int dw, input int yw);
    longint m;
    int     w;
    m = ((64'sd1 << dw) - 1)
      + longint'(taps) * ((64'sd1 << dw) - 1) * ((64'sd1 << (yw - 1)) + (64'sd1 << dw) - 1);
    w = 1;
    for (int i = 0; i < 62; i++) begin
      if ((64'sd1 << (w - 1)) <= m) w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/cnn_cell_sat.sv
// rtl/cnn_cell_sat.sv - shift, optional round-half-up (CNN_CELL_ROUND_EN) and symmetric clamp
module cnn_cell_sat #(
  parameter int ACC_W     = 24,
  parameter int YW        = 9,
  parameter int OUT_SHIFT = 0,
  parameter int LIMIT     = 255
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic        [YW-1:0]    y_o,
  output logic                    sat_o
);

  localparam logic signed [ACC_W-1:0] POS_LIM = ACC_W'(LIMIT);
  localparam logic signed [ACC_W-1:0] NEG_LIM = -POS_LIM;

  logic signed [ACC_W-1:0] pre;
  logic signed [ACC_W-1:0] shifted;

`ifdef CNN_CELL_ROUND_EN
  localparam int RND_SH = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
  localparam logic signed [ACC_W-1:0] RND = (OUT_SHIFT > 0) ? (ACC_W'(1) << RND_SH) : '0;
  assign pre = acc_i + RND;
`else
  assign pre = acc_i;
`endif

  assign shifted = pre >>> OUT_SHIFT;

  always_comb begin
    y_o   = shifted[YW-1:0];
    sat_o = 1'b0;
    if (shifted > POS_LIM) begin
      y_o   = POS_LIM[YW-1:0];
      sat_o = 1'b1;
    end else if (shifted < NEG_LIM) begin
      y_o   = NEG_LIM[YW-1:0];
      sat_o = 1'b1;
    end
  end

endmodule

// File: rtl/cnn_cell_engine.sv
// rtl/cnn_cell_engine.sv - streamed CNN cell update x = I + sum(A*Y + B*U), saturated output
// Optional rounding in the output stage is enabled by defining CNN_CELL_ROUND_EN.
module cnn_cell_engine
  import cnn_cell_pkg::*;
#(
  parameter int TAPS      = CNN_TAPS,
  parameter int DW        = CNN_DW,
  parameter int YW        = CNN_YW,
  parameter int ACC_W     = CNN_ACC_W,
  parameter int OUT_SHIFT = 0,
  parameter int LIMIT     = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_b,
  input  logic [DW-1:0] in_u,
  input  logic [YW-1:0] in_y,
  input  logic [DW-1:0] in_bias,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [YW-1:0] out_y,
  output logic          out_sat,
  output logic          busy
);

  localparam int PW    = DW + YW + 1;
  localparam int CNT_W = (TAPS < 2) ? 1 : $clog2(TAPS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TAPS - 1);

  cnn_state_e              state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        tap_cnt_q, tap_cnt_d;
  logic [YW-1:0]           out_y_q, out_y_d;
  logic                    out_sat_q, out_sat_d;

  logic signed [PW-1:0]    a_ext, y_ext, ay;
  logic [2*DW-1:0]         bu;
  logic signed [ACC_W-1:0] beat_sum, bias_ext;
  logic [YW-1:0]           sat_y;
  logic                    sat_flag;

  // A is zero-extended so the product is a true signed A*Y at full precision.
  assign a_ext    = {{(YW + 1){1'b0}}, in_a};
  assign y_ext    = {{(DW + 1){in_y[YW-1]}}, in_y};
  assign ay       = a_ext * y_ext;
  assign bu       = {{DW{1'b0}}, in_b} * {{DW{1'b0}}, in_u};
  assign beat_sum = {{(ACC_W - PW){ay[PW-1]}}, ay} + {{(ACC_W - 2*DW){1'b0}}, bu};
  assign bias_ext = {{(ACC_W - DW){1'b0}}, in_bias};

  cnn_cell_sat #(
    .ACC_W    (ACC_W),
    .YW       (YW),
    .OUT_SHIFT(OUT_SHIFT),
    .LIMIT    (LIMIT)
  ) u_sat (
    .acc_i(acc_q),
    .y_o  (sat_y),
    .sat_o(sat_flag)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      tap_cnt_q <= '0;
      out_y_q   <= '0;
      out_sat_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      tap_cnt_q <= tap_cnt_d;
      out_y_q   <= out_y_d;
      out_sat_q <= out_sat_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    tap_cnt_d = tap_cnt_q;
    out_y_d   = out_y_q;
    out_sat_d = out_sat_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d = bias_ext + beat_sum;
          if (TAPS == 1) begin
            tap_cnt_d = '0;
            state_d   = ST_SAT;
          end else begin
            tap_cnt_d = CNT_W'(1);
            state_d   = ST_ACCUM;
          end
        end
      end
      ST_ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d = acc_q + beat_sum;
          if (tap_cnt_q == LAST_CNT) begin
            tap_cnt_d = '0;
            state_d   = ST_SAT;
          end else begin
            tap_cnt_d = tap_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_SAT: begin
        out_y_d   = sat_y;
        out_sat_d = sat_flag;
        state_d   = ST_OUT;
      end
      ST_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign out_y   = out_y_q;
  assign out_sat = out_sat_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cnn_cell_engine.sv
// tb/tb_cnn_cell_engine.sv - directed and randomized checks of cnn_cell_engine against an arithmetic model
module tb_cnn_cell_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, out_sat, busy;
  logic [7:0] in_a, in_b, in_u, in_bias;
  logic [8:0] in_y, out_y;

  logic       r_in_valid, r_in_ready, r_out_valid, r_out_ready, r_out_sat, r_busy;
  logic [7:0] r_in_a, r_in_b, r_in_u, r_in_bias;
  logic [8:0] r_in_y, r_out_y;

  int checks = 0;
  int errors = 0;

  logic [7:0]        ca [9];
  logic [7:0]        cb [9];
  logic [7:0]        cu [9];
  logic signed [8:0] cy [9];
  logic [7:0]        cbias;

  always #5 clk = ~clk;

  cnn_cell_engine dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_u(in_u), .in_y(in_y), .in_bias(in_bias),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_sat(out_sat), .busy(busy)
  );

  cnn_cell_engine #(.OUT_SHIFT(2)) dut_r (
    .clk(clk), .rst(rst),
    .in_valid(r_in_valid), .in_ready(r_in_ready),
    .in_a(r_in_a), .in_b(r_in_b), .in_u(r_in_u), .in_y(r_in_y), .in_bias(r_in_bias),
    .out_valid(r_out_valid), .out_ready(r_out_ready),
    .out_y(r_out_y), .out_sat(r_out_sat), .busy(r_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // Output rule: shift (floor, or round half up when enabled), then clamp to +-255.
  function automatic void model(input longint acc, input int sh, output longint y, output bit sat);
    longint s;
    s = acc;
`ifdef CNN_CELL_ROUND_EN
    if (sh > 0) s = s + (longint'(1) << (sh - 1));
`endif
    s = s >>> sh;
    if (s > 255) begin
      y = 255; sat = 1'b1;
    end else if (s < -255) begin
      y = -255; sat = 1'b1;
    end else begin
      y = s; sat = 1'b0;
    end
  endfunction

  function automatic longint cell_acc();
    longint acc;
    acc = longint'(cbias);
    for (int k = 0; k < 9; k++)
      acc = acc + longint'(ca[k]) * longint'(cy[k]) + longint'(cb[k]) * longint'(cu[k]);
    return acc;
  endfunction

  task automatic fill(input logic [7:0] a, input logic [7:0] b, input logic [7:0] u,
                      input logic signed [8:0] y, input logic [7:0] bias);
    for (int k = 0; k < 9; k++) begin
      ca[k] = a; cb[k] = b; cu[k] = u; cy[k] = y;
    end
    cbias = bias;
  endtask

  task automatic drive_beat(input int k);
    in_valid = 1'b1;
    in_a = ca[k]; in_b = cb[k]; in_u = cu[k]; in_y = cy[k];
    in_bias = (k == 0) ? cbias : 8'($urandom);
  endtask

  task automatic run_cell(input string tag, input int bp, input int gap_max, input bit hold_valid);
    longint ey;
    bit     es;
    model(cell_acc(), 0, ey, es);
    for (int k = 0; k < 9; k++) begin
      repeat ($urandom_range(gap_max)) begin
        @(posedge clk); #1;
      end
      drive_beat(k);
      if (k == 0 || k == 8) chk({tag, ".in_ready"}, 64'(in_ready), 64'(1));
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    chk({tag, ".lat_sat"}, 64'(out_valid), 64'(0));
    chk({tag, ".busy"}, 64'(busy), 64'(1));
    @(posedge clk); #1;
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(1));
    chk({tag, ".out_y"}, $signed(out_y), ey);
    chk({tag, ".out_sat"}, 64'(out_sat), 64'(es));
    if (hold_valid) begin
      in_valid = 1'b1; in_a = 8'($urandom); in_y = 9'($urandom);
    end
    for (int c = 0; c < bp; c++) begin
      @(posedge clk); #1;
      chk({tag, ".bp_valid"}, 64'(out_valid), 64'(1));
      chk({tag, ".bp_y"}, $signed(out_y), ey);
      chk({tag, ".bp_ready"}, 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk({tag, ".post_valid"}, 64'(out_valid), 64'(0));
    chk({tag, ".post_ready"}, 64'(in_ready), 64'(1));
    chk({tag, ".post_busy"}, 64'(busy), 64'(0));
  endtask

  task automatic r_cell(input logic signed [8:0] y0);
    longint ey;
    bit     es;
    model(longint'(y0), 2, ey, es);
    for (int k = 0; k < 9; k++) begin
      r_in_valid = 1'b1;
      r_in_a = (k == 0) ? 8'd1 : 8'd0;
      r_in_y = (k == 0) ? y0 : 9'd0;
      @(posedge clk); #1;
    end
    r_in_valid = 1'b0;
    @(posedge clk); #1;
    chk("round.out_valid", 64'(r_out_valid), 64'(1));
    chk("round.out_y", $signed(r_out_y), ey);
    chk("round.out_sat", 64'(r_out_sat), 64'(es));
    r_out_ready = 1'b1;
    @(posedge clk); #1;
    r_out_ready = 1'b0;
  endtask

  initial begin
    int v;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_u = '0; in_y = '0; in_bias = '0;
    r_in_valid = 1'b0; r_out_ready = 1'b0;
    r_in_a = '0; r_in_b = '0; r_in_u = '0; r_in_y = '0; r_in_bias = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.in_ready", 64'(in_ready), 64'(1));
    chk("reset.out_valid", 64'(out_valid), 64'(0));
    chk("reset.out_y", 64'(out_y), 64'(0));
    chk("reset.out_sat", 64'(out_sat), 64'(0));
    chk("reset.busy", 64'(busy), 64'(0));
    rst = 1'b0;

    fill(8'd1, 8'd0, 8'd0, 9'sd1, 8'd0);
    run_cell("unity", 0, 0, 1'b0);
    chk("unity.const_y", 64'(out_y), 64'(9));

    fill(8'd255, 8'd255, 8'd255, 9'sd255, 8'd255);
    run_cell("pos_clamp", 0, 0, 1'b0);
    chk("pos_clamp.const_y", $signed(out_y), 64'(255));

    fill(8'd255, 8'd0, 8'd0, -9'sd256, 8'd0);
    run_cell("neg_clamp", 0, 0, 1'b0);
    chk("neg_clamp.const_y", $signed(out_y), -64'sd255);
    chk("neg_clamp.const_sat", 64'(out_sat), 64'(1));

    fill(8'd3, 8'd2, 8'd5, -9'sd7, 8'd40);
    run_cell("backpressure", 5, 0, 1'b1);
    fill(8'd1, 8'd0, 8'd0, 9'sd1, 8'd0);
    run_cell("after_bp", 0, 0, 1'b0);

    fill(8'd255, 8'd255, 8'd255, 9'sd255, 8'd255);
    run_cell("pre_reset", 0, 0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      drive_beat(k);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst.out_y", 64'(out_y), 64'(0));
    chk("midrst.out_sat", 64'(out_sat), 64'(0));
    chk("midrst.out_valid", 64'(out_valid), 64'(0));
    chk("midrst.busy", 64'(busy), 64'(0));
    chk("midrst.in_ready", 64'(in_ready), 64'(1));
    fill(8'd1, 8'd0, 8'd0, 9'sd1, 8'd0);
    run_cell("midrst.unity", 0, 0, 1'b0);

    for (int n = 0; n < 12; n++) begin
      int mode;
      mode = int'($urandom_range(2));
      for (int k = 0; k < 9; k++) begin
        case (mode)
          0: begin
            ca[k] = 8'($urandom); cb[k] = 8'($urandom); cu[k] = 8'($urandom); cy[k] = 9'($urandom);
          end
          1: begin
            ca[k] = 8'($urandom_range(3)); cb[k] = 8'($urandom_range(3));
            cu[k] = 8'($urandom_range(15));
            v = int'($urandom_range(40)) - 20; cy[k] = v[8:0];
          end
          default: begin
            ca[k] = 8'($urandom_range(7)); cb[k] = 8'd0; cu[k] = 8'($urandom);
            v = -int'($urandom_range(64)); cy[k] = v[8:0];
          end
        endcase
      end
      cbias = (mode == 0) ? 8'($urandom) : 8'($urandom_range(15));
      run_cell("random", int'($urandom_range(3)), 2, n[0]);
    end

    r_cell(9'sd6);
    r_cell(-9'sd6);
    for (int n = 0; n < 4; n++) begin
      v = int'($urandom_range(60)) - 30;
      r_cell(v[8:0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
